// File: rtl/dds_freq_meter_pkg.sv
// rtl/dds_freq_meter_pkg.sv - shared DDS constants, FSM states and sizing helpers
package dds_freq_meter_pkg;

    localparam int DDS_N_DEFAULT = 8;
    localparam int DDS_K_DEFAULT = 2;

    // Counter width and dividend for the default configuration.
    localparam int DDS_CNT_W_DEFAULT    = DDS_N_DEFAULT + 2 + DDS_K_DEFAULT;
    localparam int DDS_DIVIDEND_DEFAULT = 1 << (DDS_N_DEFAULT + 1 + DDS_K_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_COUNT  = 3'd2,
        ST_DIVIDE = 3'd3,
        ST_DONE   = 3'd4
    } dds_state_e;

    // Cycle counter width: wide enough for P periods of the slowest tuning word.
    function automatic int dds_cnt_width(input int n, input int k);
        return n + 2 + k;
    endfunction

    // log2 of the dividend 2^(N+1+K).
    function automatic int dds_dividend_log2(input int n, input int k);
        return n + 1 + k;
    endfunction

endpackage

// File: rtl/dds_serial_divider.sv
// rtl/dds_serial_divider.sv - restoring divider, one quotient bit per cycle, fixed latency
module dds_serial_divider
    import dds_freq_meter_pkg::*;
#(
    parameter int N = DDS_N_DEFAULT,
    parameter int K = DDS_K_DEFAULT
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [N+K+1:0]   dividend_i,
    input  logic [N+K+1:0]   divisor_i,
    output logic             done_o,
    output logic [N:0]       quotient_o
);

    localparam int DW   = dds_cnt_width(N, K);
    localparam int QW   = N + 1;
    localparam int CNTW = $clog2(QW + 1);

    // Only the low QW quotient bits are produced: the caller guarantees the
    // dividend's upper bits are already smaller than the divisor, so the
    // first partial remainder is simply those upper bits.
    logic [DW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   den_q, den_d;
    logic [QW-1:0]   num_q, num_d;
    logic [QW-1:0]   quo_q, quo_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;
    logic            done_q, done_d;
    logic [DW:0]     trial;
    logic [DW-1:0]   diff;

    // Next-state: load on start, then one shift/compare/subtract step per cycle.
    always_comb begin
        rem_d  = rem_q;
        den_d  = den_q;
        num_d  = num_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        trial  = {rem_q, num_q[QW-1]};
        diff   = trial[DW-1:0] - den_q;
        if (start_i) begin
            rem_d = dividend_i >> QW;
            num_d = dividend_i[QW-1:0];
            den_d = divisor_i;
            quo_d = '0;
            cnt_d = CNTW'(QW);
            run_d = 1'b1;
        end else if (run_q) begin
            if (trial >= {1'b0, den_q}) begin
                rem_d = diff;
                quo_d = {quo_q[QW-2:0], 1'b1};
            end else begin
                rem_d = trial[DW-1:0];
                quo_d = {quo_q[QW-2:0], 1'b0};
            end
            num_d = num_q << 1;
            cnt_d = cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Datapath and control registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rem_q  <= '0;
            den_q  <= '0;
            num_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            den_q  <= den_d;
            num_q  <= num_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/dds_freq_meter.sv
// rtl/dds_freq_meter.sv - measures a DDS output period and estimates its tuning word
module dds_freq_meter
    import dds_freq_meter_pkg::*;
#(
    parameter int N = DDS_N_DEFAULT,
    parameter int K = DDS_K_DEFAULT
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       sig_in_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       valid_o,
    output logic [N:0] freq_out_o,
    output logic       error_o
);

    localparam int            CW       = dds_cnt_width(N, K);
    localparam int            EW       = K + 1;
    localparam int            P        = 1 << K;
    localparam logic [CW-1:0] C_MAX    = '1;
    localparam logic [CW-1:0] DIVIDEND = {1'b1, {dds_dividend_log2(N, K){1'b0}}};

    logic sync1_q, sync2_q, prev_q, edge_q;

    dds_state_e    state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic [EW-1:0] e_q, e_d;
    logic [N:0]    freq_q, freq_d;
    logic          err_q, err_d;

    logic          div_start;
    logic          div_done;
    logic [N:0]    div_quot;

    // Two-flop synchronizer followed by a registered rising-edge detector.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sig_in_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end

    // Measurement FSM: counters, result capture and divider launch.
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        e_d       = e_q;
        freq_d    = freq_q;
        err_d     = err_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    c_d     = '0;
                    e_d     = '0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (c_q == C_MAX) begin
                    freq_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (edge_q) begin
                    // The arming edge only marks the phase reference.
                    c_d     = '0;
                    e_d     = '0;
                    state_d = ST_COUNT;
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            ST_COUNT: begin
                if (c_q == C_MAX) begin
                    freq_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    c_d = c_q + CW'(1);
                    if (edge_q) begin
                        e_d = e_q + EW'(1);
                        if (e_q == EW'(P - 1)) begin
                            // c_d now spans exactly P periods; hand it to the divider.
                            div_start = 1'b1;
                            state_d   = ST_DIVIDE;
                        end
                    end
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    freq_d  = div_quot;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and result registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            e_q     <= '0;
            freq_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            e_q     <= e_d;
            freq_q  <= freq_d;
            err_q   <= err_d;
        end
    end

    dds_serial_divider #(
        .N (N),
        .K (K)
    ) u_div (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (div_start),
        .dividend_i (DIVIDEND),
        .divisor_i  (c_d),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    assign busy_o     = (state_q != ST_IDLE);
    assign valid_o    = (state_q == ST_DONE);
    assign freq_out_o = freq_q;
    assign error_o    = err_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// tb/tb_dds_freq_meter.sv - self-checking bench for dds_freq_meter
module tb_dds_freq_meter;

    localparam int N = 8;
    localparam int K = 2;
    localparam int P = 1 << K;

    logic       clock = 1'b0;
    logic       reset;
    logic       sig_in;
    logic       start;
    logic       busy;
    logic       valid;
    logic [N:0] freq_out;
    logic       error;

    always #5 clock = ~clock;

    dds_freq_meter #(.N(N), .K(K)) dut (
        .clock_i    (clock),
        .reset_i    (reset),
        .sig_in_i   (sig_in),
        .start_i    (start),
        .busy_o     (busy),
        .valid_o    (valid),
        .freq_out_o (freq_out),
        .error_o    (error)
    );

    typedef struct {
        int f;
        int lo;
        int hi;
        bit hold;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [8:0] acc      = '0;
    int         f_step   = 0;
    int         rises[$];
    int         last_freq = 0;
    int         last_err  = 0;
    int         valid_count = 0;
    int         valid_cyc   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One clock: observe just after the edge, then drive the next DDS sample.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (reset) begin
            last_freq = 0;
            last_err  = 0;
        end else if (valid) begin
            valid_count++;
            valid_cyc = cyc;
            last_freq = int'(freq_out);
            last_err  = int'(error);
        end else begin
            n_checks++;
            if (int'(freq_out) != last_freq || int'(error) != last_err) begin
                n_fail++;
                $display("FAIL hold: freq %0d err %0d changed without valid, expected %0d/%0d",
                         freq_out, error, last_freq, last_err);
            end
        end
        acc = acc + 9'(f_step);
        if (acc[8] && !sig_in) rises.push_back(cyc);
        sig_in = acc[8];
    endtask

    // Run one measurement and compare against the period model built from rise times.
    task automatic measure(input int f, input bit hold, output int got);
        int s, vc0, t, idx, c_ref, exp_freq, exp_lat;
        got = -1;
        f_step = f;
        rises.delete();
        repeat ($urandom_range(3, 40)) step();
        check("idle_busy", int'(busy), 0);
        s     = cyc;
        vc0   = valid_count;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        t = 0;
        while (valid_count == vc0 && t < 6000) begin
            step();
            t++;
        end
        if (valid_count == vc0) begin
            start = 1'b0;
            check("valid_timeout", 0, 1);
            return;
        end
        got = last_freq;
        idx = -1;
        for (int i = 0; i < rises.size(); i++)
            if (idx < 0 && rises[i] >= s - 2) idx = i;
        if (idx < 0 || idx + P >= rises.size()) begin
            check("model_edges", rises.size(), idx + P + 1);
        end else begin
            c_ref    = rises[idx + P] - rises[idx];
            exp_freq = (1 << (N + 1 + K)) / c_ref;
            exp_lat  = rises[idx + P] + 3 + 1 + (N + 2);
            check("freq", got, exp_freq);
            check("error", last_err, 0);
            check("latency", valid_cyc, exp_lat);
        end
        // A start held into the DONE cycle must not retrigger.
        step();
        start = 1'b0;
        check("busy_after_done", int'(busy), 0);
        repeat (20) step();
        check("single_valid", valid_count - vc0, 1);
        check("no_restart", int'(busy), 0);
    endtask

    initial begin
        vec_t vecs[6];
        int   got, s, vc0, t;

        vecs = '{
            '{16,  16,  16,  1'b0},
            '{256, 256, 256, 1'b0},
            '{5,   4,   5,   1'b0},
            '{64,  64,  64,  1'b1},
            '{128, 128, 128, 1'b0},
            '{16,  16,  16,  1'b1}
        };

        reset  = 1'b1;
        start  = 1'b0;
        sig_in = 1'b0;
        repeat (3) step();
        check("rst_busy",  int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_freq",  int'(freq_out), 0);
        check("rst_error", int'(error), 0);
        reset = 1'b0;
        step();

        foreach (vecs[i]) begin
            measure(vecs[i].f, vecs[i].hold, got);
            check_range($sformatf("table_f%0d", vecs[i].f), got, vecs[i].lo, vecs[i].hi);
        end

        for (int r = 0; r < 8; r++) begin
            measure(int'($urandom_range(3, 256)), bit'($urandom_range(0, 1)), got);
        end

        // Reset in the middle of COUNT aborts with no valid and clears the result.
        f_step = 16;
        rises.delete();
        repeat (5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (70) step();
        check("mid_busy", int'(busy), 1);
        vc0   = valid_count;
        reset = 1'b1;
        step();
        check("abort_busy",  int'(busy), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_freq",  int'(freq_out), 0);
        check("abort_error", int'(error), 0);
        reset = 1'b0;
        repeat (300) step();
        check("abort_no_valid", valid_count - vc0, 0);
        check("abort_freq_held", int'(freq_out), 0);
        measure(16, 1'b0, got);
        check("after_abort_f16", got, 16);

        // Silent input: the cycle counter saturates and the error result is reported.
        f_step = 0;
        acc    = '0;
        sig_in = 1'b0;
        repeat (6) step();
        s     = cyc;
        vc0   = valid_count;
        start = 1'b1;
        step();
        start = 1'b0;
        t = 0;
        while (valid_count == vc0 && t < 5000) begin
            step();
            t++;
        end
        check("sat_valid", valid_count - vc0, 1);
        check("sat_error", last_err, 1);
        check("sat_freq", last_freq, 0);
        check_range("sat_latency", valid_cyc - s, 4096, 4098);
        step();
        check("sat_idle", int'(busy), 0);

        measure(256, 1'b0, got);
        check("recover_f256", got, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
